fetch_prefetch_unit: RTL

Parametrised RV32 instruction-fetch stage with a decoupled prefetch queue. It issues PC requests to instruction memory over a req/gnt/rvalid handshake with variable latency. It buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode with valid/ready backpressure (stall). Redirects from execute (taken branch or jump) flush the queue and discard in-flight responses. It sits between the PC-target mux in execute and the decode stage, replacing the fixed single-register IF/ID latch.

---
 rtl/fetch_prefetch_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//
// RV32 instruction-fetch stage with a decoupled prefetch queue. It sits between
// the PC-target mux in execute and the decode stage.
//
// The unit issues fetch requests over a req/gnt/rvalid handshake with variable
// latency. Each returned word is paired with its PC and buffered in a DEPTH-entry
// FIFO. Decode drains that FIFO with valid/ready. When execute redirects the PC,
// the queue is flushed and every response still in flight is counted off and
// discarded.
//
// Ports
//   clk, rst                      clock (posedge); synchronous active-low reset
//   redirect_i, redirect_pc_i     execute-stage redirect and its target
//   imem_req_o, imem_addr_o       fetch request and fetch PC
//   imem_gnt_i                    memory accepts the request this cycle
//   imem_rvalid_i, imem_rdata_i   in-order response and instruction word
//   valid_o, ready_i              handshake toward decode (ready_i=0 stalls)
//   instr_o, pc_o, pc_plus4_o     head entry; all zero when valid_o is low

module fetch_prefetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter int               MAX_OUT  = 2,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1) + 1;

    logic [XLEN-1:0] fetch_pc;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [OW-1:0]   count;

    logic [XLEN-1:0] tag_mem [MAX_OUT];
    logic [TW-1:0]   tag_rd;
    logic [TW-1:0]   tag_wr;

    // live_out: granted requests whose data will be kept.
    // drop_cnt: granted requests orphaned by a redirect; their data is thrown away.
    logic [CW-1:0]   live_out;
    logic [CW-1:0]   drop_cnt;

    logic out_credit;
    logic q_credit;
    logic rsp_legal;
    logic fire_req;
    logic accept_rsp;
    logic drop_rsp;
    logic pop;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
    endfunction

    // The queue credit counts live requests as well as buffered entries. Because
    // of this, every response that is kept is guaranteed a free slot.
    always_comb begin
        out_credit  = (32'(live_out) + 32'(drop_cnt)) < 32'(MAX_OUT);
        q_credit    = (32'(count) + 32'(live_out)) < 32'(DEPTH);
        rsp_legal   = (live_out != '0) || (drop_cnt != '0);

        imem_req_o  = rst && !redirect_i && out_credit && q_credit;
        imem_addr_o = rst ? fetch_pc : '0;
        valid_o     = rst && !redirect_i && (count != '0);

        instr_o     = '0;
        pc_o        = '0;
        pc_plus4_o  = '0;
        if (valid_o) begin
            instr_o    = instr_mem[rd_ptr];
            pc_o       = pc_mem[rd_ptr];
            pc_plus4_o = pc_mem[rd_ptr] + XLEN'(4);
        end

        fire_req   = imem_req_o && imem_gnt_i;
        drop_rsp   = rst && !redirect_i && imem_rvalid_i && (drop_cnt != '0);
        accept_rsp = rst && !redirect_i && imem_rvalid_i && (drop_cnt == '0) && (live_out != '0);
        pop        = valid_o && ready_i;
    end

    // Storage arrays carry no reset. The occupancy count and the pointers decide
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (fire_req) begin
            tag_mem[tag_wr] <= fetch_pc;
        end
        if (accept_rsp) begin
            pc_mem[wr_ptr]    <= tag_mem[tag_rd];
            instr_mem[wr_ptr] <= imem_rdata_i;
        end
    end

    // A redirect abandons everything buffered. Requests still in flight move
    // into drop_cnt. An rvalid arriving in the redirect cycle is already one of
    // those abandoned responses, so it is subtracted immediately.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            live_out <= '0;
            drop_cnt <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            live_out <= '0;
            drop_cnt <= drop_cnt + live_out - CW'(imem_rvalid_i && rsp_legal);
        end else begin
            if (fire_req) begin
                tag_wr   <= tag_next(tag_wr);
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (drop_rsp) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (accept_rsp) begin
                tag_rd <= tag_next(tag_rd);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            live_out <= live_out + CW'(fire_req) - CW'(accept_rsp);
            count    <= count + OW'(accept_rsp) - OW'(pop);
        end
    end

    // An rvalid with nothing outstanding means the memory side is broken. The
    // logic above ignores it.
    a_rvalid_legal: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid_i |-> rsp_legal);

    // Credit only grows while a request waits. An ungranted request therefore
    // persists unchanged unless a redirect retargets it.
    a_req_hold: assert property (@(posedge clk) disable iff (!rst)
        (imem_req_o && !imem_gnt_i) |=> (redirect_i || (imem_req_o && $stable(imem_addr_o))));

endmodule
